// File: rtl/apb_mst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : apb_mst_arbiter
//  Purpose  : Round-robin arbiter that shares one 32-bit APB slave port
//             between N_MST APB masters. It regenerates the SETUP/ACCESS
//             phases toward the slave, returns the response to the granted
//             master only, and uses a watchdog to end hung slave transfers
//             with an error.
//  Ports    : clk_i / rst_i        clock, async active-high reset
//             m_*_i / m_*_o        flattened per-master APB requester side
//             s_*_o / s_*_i        single APB slave side
//             timeout_o            one-cycle pulse when the watchdog fires
//             grant_o              current or last granted master index
//  Revision : 1.0  initial release
// ============================================================================
module apb_mst_arbiter #(
    parameter int N_MST          = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_MST-1:0]            m_psel_i,
    input  logic [N_MST-1:0]            m_penable_i,
    input  logic [N_MST*ADDR_WIDTH-1:0] m_paddr_i,
    input  logic [N_MST-1:0]            m_pwrite_i,
    input  logic [N_MST*32-1:0]         m_pwdata_i,
    output logic [N_MST*32-1:0]         m_prdata_o,
    output logic [N_MST-1:0]            m_pready_o,
    output logic [N_MST-1:0]            m_pslverr_o,
    output logic                        s_psel_o,
    output logic                        s_penable_o,
    output logic                        s_pwrite_o,
    output logic [ADDR_WIDTH-1:0]       s_paddr_o,
    output logic [31:0]                 s_pwdata_o,
    input  logic [31:0]                 s_prdata_i,
    input  logic                        s_pready_i,
    input  logic                        s_pslverr_i,
    output logic                        timeout_o,
    output logic [$clog2(N_MST)-1:0]    grant_o
);

    localparam int GW = $clog2(N_MST);
    // Counter must hold TIMEOUT_CYCLES; keep at least one bit when disabled.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] C_CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] C_CNT_LIM = CW'(TIMEOUT_CYCLES);
    localparam bit            C_WD_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  gnt_q,   gnt_d;
    logic [GW-1:0]  rr_q,    rr_d;
    logic [CW-1:0]  cnt_q,   cnt_d;

    logic           w_found;
    logic [GW-1:0]  w_pick;
    logic [GW-1:0]  w_rr_next;
    logic [CW-1:0]  w_cnt_inc;
    logic           w_timeout_hit;
    logic           w_penable_unused;

    // Masters' own PENABLE carries no information for the arbiter.
    assign w_penable_unused = ^m_penable_i;

    // ------------------------------------------------------------------
    // Round-robin pick: first requester at or after rr_q, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_pick  = rr_q;
        for (int k = 0; k < N_MST; k++) begin
            int idx;
            idx = (int'(rr_q) + k) % N_MST;
            if (!w_found && m_psel_i[idx]) begin
                w_found = 1'b1;
                w_pick  = GW'(idx);
            end
        end
    end

    assign w_rr_next = (gnt_q == GW'(N_MST - 1)) ? '0 : gnt_q + 1'b1;

    // Saturating increment; the compare uses the incremented value so the
    // error lands in ACCESS cycle TIMEOUT_CYCLES (first ACCESS cycle = 1).
    assign w_cnt_inc     = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign w_timeout_hit = C_WD_EN && (w_cnt_inc >= C_CNT_LIM);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and master-side response
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        s_psel_o    = 1'b0;
        s_penable_o = 1'b0;
        m_pready_o  = '0;
        m_pslverr_o = '0;
        m_prdata_o  = '0;
        timeout_o   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (w_found) begin
                    gnt_d   = w_pick;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                s_psel_o = 1'b1;
                state_d  = ST_ACCESS;
            end

            ST_ACCESS: begin
                s_psel_o    = 1'b1;
                s_penable_o = 1'b1;
                cnt_d       = w_cnt_inc;
                // Slave response has priority over a coincident timeout.
                // A master that dropped PSEL mid-transfer gets no response.
                if (s_pready_i) begin
                    if (m_psel_i[gnt_q]) begin
                        m_pready_o[gnt_q]                   = 1'b1;
                        m_pslverr_o[gnt_q]                  = s_pslverr_i;
                        m_prdata_o[int'(gnt_q)*32 +: 32]    = s_prdata_i;
                    end
                    rr_d    = w_rr_next;
                    state_d = ST_IDLE;
                end else if (w_timeout_hit) begin
                    timeout_o = 1'b1;
                    if (m_psel_i[gnt_q]) begin
                        m_pready_o[gnt_q]  = 1'b1;
                        m_pslverr_o[gnt_q] = 1'b1;
                    end
                    rr_d    = w_rr_next;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Slave request mux; held at zero in IDLE so reset drives all-zero.
    // ------------------------------------------------------------------
    always_comb begin
        s_paddr_o  = '0;
        s_pwdata_o = '0;
        s_pwrite_o = 1'b0;
        if (state_q != ST_IDLE) begin
            s_paddr_o  = m_paddr_i[int'(gnt_q)*ADDR_WIDTH +: ADDR_WIDTH];
            s_pwdata_o = m_pwdata_i[int'(gnt_q)*32 +: 32];
            s_pwrite_o = m_pwrite_i[gnt_q];
        end
    end

    assign grant_o = gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_mst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_mst_arbiter
//  Purpose  : Self-checking bench for apb_mst_arbiter (N_MST=2,
//             TIMEOUT_CYCLES=4) using a per-cycle vector table plus
//             directed sequences for wait states, timeout, reset and
//             PSEL drop.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_mst_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [N-1:0]    m_psel_i = '0;
    logic [N-1:0]    m_penable_i;
    logic [N*AW-1:0] m_paddr_i;
    logic [N-1:0]    m_pwrite_i;
    logic [N*32-1:0] m_pwdata_i;
    logic [N*32-1:0] m_prdata_o;
    logic [N-1:0]    m_pready_o;
    logic [N-1:0]    m_pslverr_o;
    logic            s_psel_o, s_penable_o, s_pwrite_o;
    logic [AW-1:0]   s_paddr_o;
    logic [31:0]     s_pwdata_o;
    logic [31:0]     s_prdata_i  = '0;
    logic            s_pready_i  = 1'b0;
    logic            s_pslverr_i = 1'b0;
    logic            timeout_o;
    logic [0:0]      grant_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    assign m_penable_i = m_psel_i;
    assign m_paddr_i   = {32'h2000_0040, 32'h1A10_1000};
    assign m_pwdata_i  = {32'h1234_5678, 32'h1111_0000};
    assign m_pwrite_i  = 2'b10;

    apb_mst_arbiter #(
        .N_MST(N), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_psel_i(m_psel_i), .m_penable_i(m_penable_i),
        .m_paddr_i(m_paddr_i), .m_pwrite_i(m_pwrite_i),
        .m_pwdata_i(m_pwdata_i), .m_prdata_o(m_prdata_o),
        .m_pready_o(m_pready_o), .m_pslverr_o(m_pslverr_o),
        .s_psel_o(s_psel_o), .s_penable_o(s_penable_o),
        .s_pwrite_o(s_pwrite_o), .s_paddr_o(s_paddr_o),
        .s_pwdata_o(s_pwdata_o), .s_prdata_i(s_prdata_i),
        .s_pready_i(s_pready_i), .s_pslverr_i(s_pslverr_i),
        .timeout_o(timeout_o), .grant_o(grant_o)
    );

    typedef struct {
        logic [1:0]  psel;
        logic        pready;
        logic        pslverr;
        logic [31:0] prdata;
        logic        e_psel;
        logic        e_pen;
        logic [1:0]  e_rdy;
        logic [1:0]  e_err;
        logic        e_gnt;
        logic [63:0] e_rdata;
        logic [31:0] e_paddr;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs in the low phase, then let outputs settle.
    task automatic step(input logic [1:0] psel, input logic rdy, input logic err,
                        input logic [31:0] rd);
        @(negedge clk_i);
        m_psel_i    = psel;
        s_pready_i  = rdy;
        s_pslverr_i = err;
        s_prdata_i  = rd;
        #1;
    endtask

    initial begin
        //        psel  rdy  err  prdata         psel pen  rdy    err    g     rdata                          paddr
        vt[0]  = '{2'b01,1'b0,1'b0,32'h0,        1'b0,1'b0,2'b00,2'b00,1'b0,64'h0,                        32'h0};
        vt[1]  = '{2'b01,1'b0,1'b0,32'hDEADBEEF, 1'b1,1'b0,2'b00,2'b00,1'b0,64'h0,                        32'h1A10_1000};
        vt[2]  = '{2'b01,1'b1,1'b0,32'hCAFEF00D, 1'b1,1'b1,2'b01,2'b00,1'b0,{32'h0,32'hCAFEF00D},        32'h1A10_1000};
        vt[3]  = '{2'b00,1'b0,1'b0,32'h0,        1'b0,1'b0,2'b00,2'b00,1'b0,64'h0,                        32'h0};
        vt[4]  = '{2'b11,1'b0,1'b0,32'h0,        1'b0,1'b0,2'b00,2'b00,1'b0,64'h0,                        32'h0};
        vt[5]  = '{2'b11,1'b0,1'b0,32'h0,        1'b1,1'b0,2'b00,2'b00,1'b1,64'h0,                        32'h2000_0040};
        vt[6]  = '{2'b11,1'b1,1'b0,32'hA5A50001, 1'b1,1'b1,2'b10,2'b00,1'b1,{32'hA5A50001,32'h0},        32'h2000_0040};
        vt[7]  = '{2'b11,1'b0,1'b0,32'h0,        1'b0,1'b0,2'b00,2'b00,1'b1,64'h0,                        32'h0};
        vt[8]  = '{2'b11,1'b0,1'b0,32'h0,        1'b1,1'b0,2'b00,2'b00,1'b0,64'h0,                        32'h1A10_1000};
        vt[9]  = '{2'b11,1'b1,1'b0,32'h2,        1'b1,1'b1,2'b01,2'b00,1'b0,{32'h0,32'h2},                32'h1A10_1000};
        vt[10] = '{2'b11,1'b0,1'b0,32'h0,        1'b0,1'b0,2'b00,2'b00,1'b0,64'h0,                        32'h0};
        vt[11] = '{2'b11,1'b0,1'b1,32'hDEADBEEF, 1'b1,1'b0,2'b00,2'b00,1'b1,64'h0,                        32'h2000_0040};
        vt[12] = '{2'b11,1'b1,1'b1,32'h3,        1'b1,1'b1,2'b10,2'b10,1'b1,{32'h3,32'h0},                32'h2000_0040};
        vt[13] = '{2'b00,1'b0,1'b0,32'h0,        1'b0,1'b0,2'b00,2'b00,1'b1,64'h0,                        32'h0};

        // Reset state
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_psel",    64'(s_psel_o),    64'h0);
        chk("rst_penable", 64'(s_penable_o), 64'h0);
        chk("rst_pready",  64'(m_pready_o),  64'h0);
        chk("rst_grant",   64'(grant_o),     64'h0);
        chk("rst_paddr",   64'(s_paddr_o),   64'h0);
        chk("rst_timeout", 64'(timeout_o),   64'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Table: single read, then alternating grants under constant requests
        for (int i = 0; i < 14; i++) begin
            step(vt[i].psel, vt[i].pready, vt[i].pslverr, vt[i].prdata);
            chk($sformatf("v%0d_psel", i),    64'(s_psel_o),    64'(vt[i].e_psel));
            chk($sformatf("v%0d_penable", i), 64'(s_penable_o), 64'(vt[i].e_pen));
            chk($sformatf("v%0d_pready", i),  64'(m_pready_o),  64'(vt[i].e_rdy));
            chk($sformatf("v%0d_pslverr", i), 64'(m_pslverr_o), 64'(vt[i].e_err));
            chk($sformatf("v%0d_grant", i),   64'(grant_o),     64'(vt[i].e_gnt));
            chk($sformatf("v%0d_prdata", i),  m_prdata_o,       vt[i].e_rdata);
            chk($sformatf("v%0d_paddr", i),   64'(s_paddr_o),   64'(vt[i].e_paddr));
            chk($sformatf("v%0d_timeout", i), 64'(timeout_o),   64'h0);
        end

        // Master 1 write with 3 wait states; ready lands in ACCESS cycle 4,
        // coinciding with the timeout limit, so the slave response wins.
        step(2'b10, 1'b0, 1'b0, 32'h0);
        chk("ws_idle_psel", 64'(s_psel_o), 64'h0);
        step(2'b10, 1'b0, 1'b0, 32'h0);
        chk("ws_setup_grant", 64'(grant_o),    64'h1);
        chk("ws_setup_pwdata", 64'(s_pwdata_o), 64'h1234_5678);
        chk("ws_setup_pwrite", 64'(s_pwrite_o), 64'h1);
        for (int w = 0; w < 3; w++) begin
            step(2'b10, 1'b0, 1'b0, 32'h0);
            chk($sformatf("ws_wait%0d_pwdata", w),  64'(s_pwdata_o),  64'h1234_5678);
            chk($sformatf("ws_wait%0d_penable", w), 64'(s_penable_o), 64'h1);
            chk($sformatf("ws_wait%0d_pready", w),  64'(m_pready_o),  64'h0);
            chk($sformatf("ws_wait%0d_timeout", w), 64'(timeout_o),   64'h0);
        end
        step(2'b10, 1'b1, 1'b0, 32'h77);
        chk("ws_done_pwdata",  64'(s_pwdata_o),  64'h1234_5678);
        chk("ws_done_pready",  64'(m_pready_o),  64'h2);
        chk("ws_done_pslverr", 64'(m_pslverr_o), 64'h0);
        chk("ws_done_timeout", 64'(timeout_o),   64'h0);
        chk("ws_done_prdata",  m_prdata_o,       {32'h77, 32'h0});

        // Watchdog: both request, slave never ready, master 0 granted first.
        step(2'b11, 1'b0, 1'b0, 32'h0);
        step(2'b11, 1'b0, 1'b0, 32'h0);
        chk("to_setup_grant", 64'(grant_o), 64'h0);
        for (int w = 1; w <= 3; w++) begin
            step(2'b11, 1'b0, 1'b0, 32'hFFFF_FFFF);
            chk($sformatf("to_acc%0d_pready", w),  64'(m_pready_o), 64'h0);
            chk($sformatf("to_acc%0d_timeout", w), 64'(timeout_o),  64'h0);
        end
        step(2'b11, 1'b0, 1'b0, 32'hFFFF_FFFF);
        chk("to_fire_pready",  64'(m_pready_o),  64'h1);
        chk("to_fire_pslverr", 64'(m_pslverr_o), 64'h1);
        chk("to_fire_prdata",  m_prdata_o,       64'h0);
        chk("to_fire_timeout", 64'(timeout_o),   64'h1);
        step(2'b11, 1'b0, 1'b0, 32'h0);
        chk("to_after_psel",    64'(s_psel_o),  64'h0);
        chk("to_after_timeout", 64'(timeout_o), 64'h0);
        step(2'b11, 1'b0, 1'b0, 32'h0);
        chk("to_next_grant", 64'(grant_o),  64'h1);
        chk("to_next_psel",  64'(s_psel_o), 64'h1);
        step(2'b11, 1'b1, 1'b0, 32'h0);
        chk("to_next_pready", 64'(m_pready_o), 64'h2);
        step(2'b00, 1'b0, 1'b0, 32'h0);

        // Asynchronous reset in ACCESS, then master 1 wins after release.
        step(2'b01, 1'b0, 1'b0, 32'h0);
        step(2'b01, 1'b0, 1'b0, 32'h0);
        step(2'b01, 1'b1, 1'b0, 32'h5);
        chk("ar_pre_pready", 64'(m_pready_o), 64'h1);
        rst_i = 1'b1;
        #1;
        chk("ar_psel",    64'(s_psel_o),    64'h0);
        chk("ar_penable", 64'(s_penable_o), 64'h0);
        chk("ar_pready",  64'(m_pready_o),  64'h0);
        chk("ar_prdata",  m_prdata_o,       64'h0);
        chk("ar_paddr",   64'(s_paddr_o),   64'h0);
        step(2'b10, 1'b0, 1'b0, 32'h0);
        rst_i = 1'b0;
        #1;
        chk("ar_rel_psel", 64'(s_psel_o), 64'h0);
        step(2'b10, 1'b0, 1'b0, 32'h0);
        chk("ar_m1_grant", 64'(grant_o),   64'h1);
        chk("ar_m1_paddr", 64'(s_paddr_o), 64'h2000_0040);
        step(2'b10, 1'b1, 1'b0, 32'h0);
        chk("ar_m1_pready", 64'(m_pready_o), 64'h2);

        // Granted master drops PSEL mid-transfer: slave completes, no response.
        step(2'b01, 1'b0, 1'b0, 32'h0);
        step(2'b01, 1'b0, 1'b0, 32'h0);
        chk("drop_setup_grant", 64'(grant_o), 64'h0);
        step(2'b00, 1'b1, 1'b0, 32'h9);
        chk("drop_psel",    64'(s_psel_o),    64'h1);
        chk("drop_penable", 64'(s_penable_o), 64'h1);
        chk("drop_pready",  64'(m_pready_o),  64'h0);
        chk("drop_prdata",  m_prdata_o,       64'h0);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("drop_idle_psel", 64'(s_psel_o), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_mst_arbiter.md
# apb_mst_arbiter

Round-robin arbiter sharing one 32-bit APB slave port between N_MST APB masters, for example host AXI-to-APB traffic and a cluster or debug requester in front of the peripheral bus. The arbiter grants one master per transfer and regenerates the SETUP/ACCESS phases toward the slave. It forwards the response to the granted master only. A programmable watchdog terminates hung slave transfers with an error, so one stuck peripheral cannot lock every master out.

## Interface
- N_MST, default 2: number of masters, 2..8.
- ADDR_WIDTH, default 32: APB address width.
- TIMEOUT_CYCLES, default 255: maximum ACCESS-phase cycles before forced termination; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- m_psel_i  in  N_MST  per-master request / PSEL.
- m_penable_i  in  N_MST  per-master PENABLE; ignored, the arbiter generates its own.
- m_paddr_i  in  N_MST*ADDR_WIDTH  per-master address.
- m_pwrite_i  in  N_MST  per-master write flag.
- m_pwdata_i  in  N_MST*32  per-master write data.
- m_prdata_o  out  N_MST*32  read data; non-zero only on the granted master in its completion cycle.
- m_pready_o  out  N_MST  completion strobe, one-hot or zero.
- m_pslverr_o  out  N_MST  error, valid with m_pready_o.
- s_psel_o, s_penable_o, s_pwrite_o  out  1  slave control.
- s_paddr_o  out  ADDR_WIDTH  slave address.
- s_pwdata_o  out  32  slave write data.
- s_prdata_i  in  32  slave read data.
- s_pready_i, s_pslverr_i  in  1  slave response.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.
- grant_o  out  $clog2(N_MST)  current or last granted master index, for debug.

## Operation
The FSM has three states: IDLE, SETUP and ACCESS.
- IDLE: if any m_psel_i is high, select the first requesting index at or after the round-robin pointer rr_q, wrapping modulo N_MST. Register it into gnt_q, then go to SETUP. With no request, stay in IDLE.
- SETUP: s_psel_o=1, s_penable_o=0. s_paddr, s_pwrite and s_pwdata are muxed combinationally from master gnt_q, which holds them stable per APB. Go to ACCESS unconditionally.
- ACCESS: s_psel_o=1, s_penable_o=1, and the watchdog counter increments every cycle.
  - On s_pready_i: m_pready_o[gnt_q]=1, m_prdata_o[gnt_q]=s_prdata_i, m_pslverr_o[gnt_q]=s_pslverr_i, all combinational. Then rr_q <= (gnt_q+1) mod N_MST and the FSM returns to IDLE.
  - Watchdog: if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES with s_pready_i still low:
    - m_pready_o[gnt_q]=1, m_pslverr_o[gnt_q]=1, m_prdata_o[gnt_q]=32'h0;
    - timeout_o pulses for that cycle;
    - the slave is abandoned: s_psel_o drops the next cycle;
    - rr_q advances and the FSM returns to IDLE.
  - The counter clears in IDLE.
- If the granted master drops m_psel_i mid-transfer (protocol violation), the slave transfer still completes. The response is discarded: m_pready_o stays 0 for that master.
- The counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates, never wrapping.

## Timing
- Reset values: all outputs 0, state IDLE, rr_q=0, gnt_q=0, counter 0.
- Reset asserted mid-transfer returns to IDLE within the same cycle (asynchronous). The slave sees s_psel_o drop immediately.
- Minimum latency, with request seen in cycle 0 and s_pready_i high at the first ACCESS cycle:
  - s_psel_o in cycle 1;
  - s_penable_o in cycle 2;
  - m_pready_o in cycle 2.
- Back-to-back: the cycle after completion is always IDLE, one arbitration bubble. Minimum period is 3 cycles per transfer.
- Simultaneous requests resolve purely by rr_q. A master re-requesting right after its grant yields to any other pending master.
- A new request arriving in SETUP or ACCESS is only sampled in IDLE.
- Timeout: the error completion occurs in ACCESS cycle number TIMEOUT_CYCLES, counting the first ACCESS cycle as 1.
- If s_pready_i and the timeout coincide in the same cycle, s_pready_i wins: the slave response is forwarded and there is no timeout_o pulse.

## Test plan
- Single master 0 read from 0x1A10_1000, slave pready in the first ACCESS cycle with prdata 0xCAFE_F00D -> m_pready_o=2'b01 at cycle 2 with prdata 0xCAFE_F00D; s_psel_o high in cycles 1-2 only.
- Both masters request continuously, rr_q=0 -> grants alternate 0,1,0,1, with grant_o visible and one IDLE cycle between transfers.
- Slave inserts 3 wait states, master 1 write of 0x1234_5678 -> s_pwdata_o stable for 5 cycles, then m_pready_o[1] pulse, m_pslverr_o=0.
- TIMEOUT_CYCLES=4 with the slave never ready -> in the 4th ACCESS cycle m_pready_o=1 and m_pslverr_o=1 on the granted master, timeout_o pulses, and the other master is granted next.
- s_pready_i in exactly the 4th ACCESS cycle with TIMEOUT_CYCLES=4 -> normal response, timeout_o=0.
- rst_i asserted during ACCESS -> all outputs 0 asynchronously. After release, a pending master 1 request is granted before master 0, because rr_q=0 but master 0 is idle.
